led_blink_arbiter: RTL and testbench

Shares the two-LED blink output (`LEDG[1:0]`, complementary blink at a programmable half-period) between `NREQ` requesters. Each requester asks for a burst of N blinks. The block grants requesters round-robin, runs the burst non-preemptively, signals completion, and inserts a one-half-period dark gap before the next grant. It sits between the board LEDs and any status sources that want to flash a code on them.

---
 rtl/led_blink_arbiter.sv | 156 +++++++++++++++
 tb/tb_led_blink_arbiter.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/led_blink_arbiter.sv
// rtl/led_blink_arbiter.sv - round-robin arbiter sharing a complementary two-LED blinker
// Each grant runs a non-preemptive burst of blinks, pulses DONE, then holds a dark gap.
module led_blink_arbiter #(
  parameter int TICK_DIV = 50000000,
  parameter int NREQ     = 4
) (
  input  logic              CLOCK_50,
  input  logic              RESET,
  input  logic [NREQ-1:0]   REQ,
  input  logic [4*NREQ-1:0] BLINKS,
  output logic [NREQ-1:0]   GNT,
  output logic [NREQ-1:0]   DONE,
  output logic              BUSY,
  output logic [1:0]        LEDG
);

  localparam int TCW = $clog2(TICK_DIV);
  localparam int PW  = $clog2(NREQ);
  localparam logic [TCW-1:0]  TC_MAX   = TCW'(TICK_DIV - 1);
  localparam logic [PW-1:0]   PTR_LAST = PW'(NREQ - 1);
  localparam logic [NREQ-1:0] ONE_HOT0 = NREQ'(1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_GAP  = 2'd2;

  logic [1:0]      state_q, state_d;
  logic [TCW-1:0]  tc_q, tc_d;
  logic [5:0]      cnt_q, cnt_d;
  logic            light_q, light_d;
  logic [PW-1:0]   ptr_q, ptr_d;
  logic [PW-1:0]   win_q, win_d;
  logic [NREQ-1:0] gnt_q, gnt_d;
  logic [NREQ-1:0] done_q, done_d;
  logic            busy_q, busy_d;
  logic [1:0]      ledg_q, ledg_d;

  logic            tick;
  logic            req_any;
  logic [PW-1:0]   pick;
  logic [3:0]      field;
  logic [4:0]      blinks_dec;

  assign tick = (tc_q == TC_MAX);

  // Scan from the highest offset down so the lowest offset from ptr wins.
  always_comb begin
    req_any = 1'b0;
    pick    = ptr_q;
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (REQ[(int'(ptr_q) + k) % NREQ]) begin
        req_any = 1'b1;
        pick    = PW'((int'(ptr_q) + k) % NREQ);
      end
    end
  end

  assign field      = BLINKS[int'(pick) * 4 +: 4];
  assign blinks_dec = (field == 4'd0) ? 5'd16 : {1'b0, field};

  always_comb begin
    state_d = state_q;
    tc_d    = tick ? '0 : tc_q + 1'b1;
    cnt_d   = cnt_q;
    light_d = light_q;
    ptr_d   = ptr_q;
    win_d   = win_q;
    gnt_d   = gnt_q;
    done_d  = '0;
    busy_d  = busy_q;
    ledg_d  = ledg_q;

    case (state_q)
      S_IDLE: begin
        tc_d = '0;
        if (req_any) begin
          state_d = S_RUN;
          win_d   = pick;
          cnt_d   = {blinks_dec, 1'b0};
          light_d = 1'b1;
          ledg_d  = 2'b01;
          gnt_d   = ONE_HOT0 << pick;
          busy_d  = 1'b1;
        end
      end

      S_RUN: begin
        if (tick) begin
          if (cnt_q == 6'd1) begin
            state_d = S_GAP;
            tc_d    = '0;
            cnt_d   = '0;
            light_d = 1'b0;
            ledg_d  = 2'b00;
            gnt_d   = '0;
            done_d  = ONE_HOT0 << win_q;
            ptr_d   = (win_q == PTR_LAST) ? '0 : win_q + 1'b1;
          end else begin
            cnt_d   = cnt_q - 6'd1;
            light_d = ~light_q;
            ledg_d  = {light_q, ~light_q};
          end
        end
      end

      S_GAP: begin
        if (tick) begin
          state_d = S_IDLE;
          tc_d    = '0;
          busy_d  = 1'b0;
        end
      end

      default: begin
        state_d = S_IDLE;
        tc_d    = '0;
        light_d = 1'b0;
        gnt_d   = '0;
        busy_d  = 1'b0;
        ledg_d  = 2'b00;
      end
    endcase
  end

  always_ff @(posedge CLOCK_50 or posedge RESET) begin
    if (RESET) begin
      state_q <= S_IDLE;
      tc_q    <= '0;
      cnt_q   <= '0;
      light_q <= 1'b0;
      ptr_q   <= '0;
      win_q   <= '0;
      gnt_q   <= '0;
      done_q  <= '0;
      busy_q  <= 1'b0;
      ledg_q  <= 2'b00;
    end else begin
      state_q <= state_d;
      tc_q    <= tc_d;
      cnt_q   <= cnt_d;
      light_q <= light_d;
      ptr_q   <= ptr_d;
      win_q   <= win_d;
      gnt_q   <= gnt_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
      ledg_q  <= ledg_d;
    end
  end

  assign GNT  = gnt_q;
  assign DONE = done_q;
  assign BUSY = busy_q;
  assign LEDG = ledg_q;

endmodule

// File: tb/tb_led_blink_arbiter.sv
// tb/tb_led_blink_arbiter.sv - directed self-checking bench for led_blink_arbiter
// Half-period of 4 cycles, four requesters; outputs sampled on the falling edge.
module tb_led_blink_arbiter;

  logic        clk;
  logic        rst;
  logic [3:0]  req;
  logic [15:0] blinks;
  logic [3:0]  gnt;
  logic [3:0]  done;
  logic        busy;
  logic [1:0]  ledg;

  int vectors;
  int miscompares;

  led_blink_arbiter #(.TICK_DIV(4), .NREQ(4)) dut (
    .CLOCK_50(clk),
    .RESET   (rst),
    .REQ     (req),
    .BLINKS  (blinks),
    .GNT     (gnt),
    .DONE    (done),
    .BUSY    (busy),
    .LEDG    (ledg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic test_reset();
    rst = 1'b1; req = 4'b1111; blinks = 16'h1111;
    repeat (3) @(negedge clk);
    vectors++; if (gnt !== 4'b0000) begin miscompares++; $display("FAIL reset_gnt got=%b exp=0000", gnt); end
    vectors++; if (ledg !== 2'b00) begin miscompares++; $display("FAIL reset_ledg got=%b exp=00", ledg); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy got=%b exp=0", busy); end
    vectors++; if (done !== 4'b0000) begin miscompares++; $display("FAIL reset_done got=%b exp=0000", done); end
    rst = 1'b0;
    @(negedge clk);
    vectors++; if (gnt !== 4'b0001) begin miscompares++; $display("FAIL release_gnt got=%b exp=0001", gnt); end
    vectors++; if (ledg !== 2'b01) begin miscompares++; $display("FAIL release_ledg got=%b exp=01", ledg); end
    vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL release_busy got=%b exp=1", busy); end
    repeat (2) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    vectors++; if (gnt !== 4'b0000) begin miscompares++; $display("FAIL async_gnt got=%b exp=0000", gnt); end
    vectors++; if (ledg !== 2'b00) begin miscompares++; $display("FAIL async_ledg got=%b exp=00", ledg); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL async_busy got=%b exp=0", busy); end
    req = 4'b0000;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      vectors++; if (done !== 4'b0000) begin miscompares++; $display("FAIL abort_done i=%0d got=%b exp=0000", i, done); end
    end
    rst = 1'b0;
  endtask

  task automatic test_single();
    logic [3:0] eg, ed;
    logic [1:0] el;
    logic       eb;
    req = 4'b0100; blinks = 16'h0100;
    for (int s = 0; s < 14; s++) begin
      @(negedge clk);
      eg = (s < 8) ? 4'b0100 : 4'b0000;
      el = (s < 4) ? 2'b01 : (s < 8) ? 2'b10 : 2'b00;
      ed = (s == 8) ? 4'b0100 : 4'b0000;
      eb = (s < 12);
      vectors++; if (gnt !== eg) begin miscompares++; $display("FAIL single_gnt s=%0d got=%b exp=%b", s, gnt, eg); end
      vectors++; if (ledg !== el) begin miscompares++; $display("FAIL single_ledg s=%0d got=%b exp=%b", s, ledg, el); end
      vectors++; if (done !== ed) begin miscompares++; $display("FAIL single_done s=%0d got=%b exp=%b", s, done, ed); end
      vectors++; if (busy !== eb) begin miscompares++; $display("FAIL single_busy s=%0d got=%b exp=%b", s, busy, eb); end
      if (s == 0) req = 4'b0000;
    end
  endtask

  task automatic test_simultaneous();
    req = 4'b1001; blinks = 16'h1111;
    for (int s = 0; s < 26; s++) begin
      @(negedge clk);
      if (s == 0) begin
        vectors++; if (gnt !== 4'b1000) begin miscompares++; $display("FAIL simul_first got=%b exp=1000", gnt); end
      end
      if (s == 8) begin
        vectors++; if (done !== 4'b1000) begin miscompares++; $display("FAIL simul_done got=%b exp=1000", done); end
      end
      if (s == 13) begin
        vectors++; if (gnt !== 4'b0001) begin miscompares++; $display("FAIL simul_second got=%b exp=0001", gnt); end
        req = 4'b0000;
      end
      if (s == 25) begin
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL simul_idle got=%b exp=0", busy); end
      end
    end
  endtask

  task automatic test_round_robin();
    logic [3:0] eg;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0; req = 4'b1111; blinks = 16'h1111;
    for (int s = 0; s < 65; s++) begin
      @(negedge clk);
      vectors++; if ($onehot0(gnt) !== 1'b1) begin miscompares++; $display("FAIL rr_gnt_onehot s=%0d got=%b", s, gnt); end
      vectors++; if ($onehot0(done) !== 1'b1) begin miscompares++; $display("FAIL rr_done_onehot s=%0d got=%b", s, done); end
      vectors++; if ((gnt & done) !== 4'b0000) begin miscompares++; $display("FAIL rr_overlap s=%0d gnt=%b done=%b", s, gnt, done); end
      if (s <= 52 && s % 13 == 0) begin
        eg = 4'b0001 << ((s / 13) % 4);
        vectors++; if (gnt !== eg) begin miscompares++; $display("FAIL rr_order s=%0d got=%b exp=%b", s, gnt, eg); end
      end
      if (s % 13 == 12) begin
        vectors++; if (gnt !== 4'b0000) begin miscompares++; $display("FAIL rr_gap s=%0d got=%b exp=0000", s, gnt); end
      end
      if (s == 52) req = 4'b0000;
      if (s == 63) begin
        vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL rr_busy_tail got=%b exp=1", busy); end
      end
      if (s == 64) begin
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL rr_busy_end got=%b exp=0", busy); end
      end
    end
  endtask

  task automatic test_encoding();
    int len, tog, exp_len, exp_tog;
    logic       pg;
    logic [1:0] pl;
    for (int c = 0; c < 2; c++) begin
      blinks  = (c == 0) ? 16'h0000 : 16'h000F;
      exp_len = (c == 0) ? 128 : 120;
      exp_tog = (c == 0) ? 32 : 30;
      req = 4'b0001;
      len = 0; tog = 0; pg = 1'b0; pl = 2'b00;
      for (int s = 0; s < 140; s++) begin
        @(negedge clk);
        if (gnt[0]) len++;
        if (pg && ledg !== pl) tog++;
        pg = gnt[0]; pl = ledg;
        if (s == 0) req = 4'b0000;
      end
      vectors++; if (len !== exp_len) begin miscompares++; $display("FAIL enc_len c=%0d got=%0d exp=%0d", c, len, exp_len); end
      vectors++; if (tog !== exp_tog) begin miscompares++; $display("FAIL enc_toggles c=%0d got=%0d exp=%0d", c, tog, exp_tog); end
      vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL enc_idle c=%0d got=%b exp=0", c, busy); end
    end
  endtask

  task automatic test_non_preempt();
    logic [3:0] eg, ed;
    int len1;
    len1 = 0;
    req = 4'b0010; blinks = 16'h0031;
    for (int s = 0; s < 42; s++) begin
      @(negedge clk);
      eg = (s < 24) ? 4'b0010 : (s < 29) ? 4'b0000 : (s < 37) ? 4'b0001 : 4'b0000;
      ed = (s == 24) ? 4'b0010 : (s == 37) ? 4'b0001 : 4'b0000;
      if (gnt[1]) len1++;
      vectors++; if (gnt !== eg) begin miscompares++; $display("FAIL np_gnt s=%0d got=%b exp=%b", s, gnt, eg); end
      vectors++; if (done !== ed) begin miscompares++; $display("FAIL np_done s=%0d got=%b exp=%b", s, done, ed); end
      if (s == 1) req = 4'b0001;
      if (s == 29) req = 4'b0000;
    end
    vectors++; if (len1 !== 24) begin miscompares++; $display("FAIL np_len got=%0d exp=24", len1); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL np_idle got=%b exp=0", busy); end
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    rst = 1'b1; req = 4'b0000; blinks = 16'h0000;
    test_reset();
    test_single();
    test_simultaneous();
    test_round_robin();
    test_encoding();
    test_non_preempt();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
